// File: rtl/bru_predict_if.sv
// Branch resolution unit bus: fetch-side predict lookup plus EX-side resolve request/response.
// With BRU_PREDICT_STATS_EN defined the bus also carries branch/mispredict statistics.
interface bru_predict_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] fetch_pc;
  logic            fetch_pred_taken;
  logic            res_valid;
  logic            stall;
  logic            flush;
  logic [2:0]      bru_op;
  logic            is_jalr;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [XLEN-1:0] imm;
  logic            pred_taken;
  logic            branch_taken;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic [XLEN-1:0] link_pc;
`ifdef BRU_PREDICT_STATS_EN
  logic [31:0]     stat_branches;
  logic [31:0]     stat_mispredicts;
`endif

  modport master (
    output fetch_pc, res_valid, stall, flush, bru_op, is_jalr, pc,
           rs1_data, rs2_data, imm, pred_taken,
`ifdef BRU_PREDICT_STATS_EN
    input  stat_branches, stat_mispredicts,
`endif
    input  fetch_pred_taken, branch_taken, redirect, redirect_pc, link_pc
  );

  modport slave (
    input  fetch_pc, res_valid, stall, flush, bru_op, is_jalr, pc,
           rs1_data, rs2_data, imm, pred_taken,
`ifdef BRU_PREDICT_STATS_EN
    output stat_branches, stat_mispredicts,
`endif
    output fetch_pred_taken, branch_taken, redirect, redirect_pc, link_pc
  );
endinterface

// File: rtl/bru_predict.sv
// EX-stage branch resolution with a bimodal 2-bit BHT and a registered one-cycle redirect.
// Optional statistics counters are enabled by defining BRU_PREDICT_STATS_EN.
module bru_predict #(
  parameter int         XLEN      = 32,
  parameter int         BHT_IDX_W = 6,
  parameter logic [1:0] BHT_INIT  = 2'b01
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  bru_predict_if.slave  bus
);
  localparam int BHT_DEPTH = 2**BHT_IDX_W;

  localparam logic [2:0] BRU_EQ  = 3'd0;
  localparam logic [2:0] BRU_NE  = 3'd1;
  localparam logic [2:0] BRU_LT  = 3'd2;
  localparam logic [2:0] BRU_GE  = 3'd3;
  localparam logic [2:0] BRU_LTU = 3'd4;
  localparam logic [2:0] BRU_GEU = 3'd5;
  localparam logic [2:0] BRU_JMP = 3'd6;

  logic [BHT_DEPTH-1:0][1:0] bht_q;
  logic                      taken_q, taken_d;
  logic                      redirect_q, redirect_d;
  logic [XLEN-1:0]           redirect_pc_q, redirect_pc_d;
  logic [XLEN-1:0]           link_pc_q, link_pc_d;

  logic [BHT_IDX_W-1:0] fetch_idx, res_idx;
  logic                 accept, is_cond, is_jmp, cond_true, taken, mispredict;
  logic                 bht_we;
  logic [1:0]           ctr_cur, ctr_nxt;
  logic [XLEN-1:0]      pc_plus4, target, jalr_sum, next_pc;
  logic                 unused_addr_bits;

  assign fetch_idx = bus.fetch_pc[BHT_IDX_W+1:2];
  assign res_idx   = bus.pc[BHT_IDX_W+1:2];
  assign unused_addr_bits = ^{bus.fetch_pc[XLEN-1:BHT_IDX_W+2], bus.fetch_pc[1:0]};

  // Pre-edge table value; a same-cycle resolve to this index is deliberately not forwarded.
  assign bus.fetch_pred_taken = bht_q[fetch_idx][1];

  // A live redirect means whatever sits in EX is wrong-path.
  assign accept = bus.res_valid & ~bus.stall & ~bus.flush & ~redirect_q;

  always_comb begin
    is_cond   = 1'b0;
    is_jmp    = 1'b0;
    cond_true = 1'b0;
    case (bus.bru_op)
      BRU_EQ:  begin is_cond = 1'b1; cond_true = (bus.rs1_data == bus.rs2_data); end
      BRU_NE:  begin is_cond = 1'b1; cond_true = (bus.rs1_data != bus.rs2_data); end
      BRU_LT:  begin is_cond = 1'b1; cond_true = ($signed(bus.rs1_data) <  $signed(bus.rs2_data)); end
      BRU_GE:  begin is_cond = 1'b1; cond_true = ($signed(bus.rs1_data) >= $signed(bus.rs2_data)); end
      BRU_LTU: begin is_cond = 1'b1; cond_true = (bus.rs1_data <  bus.rs2_data); end
      BRU_GEU: begin is_cond = 1'b1; cond_true = (bus.rs1_data >= bus.rs2_data); end
      BRU_JMP: is_jmp = 1'b1;
      default: ;
    endcase
  end

  assign taken      = is_jmp | (is_cond & cond_true);
  // Jumps are never predicted at fetch, so they always redirect.
  assign mispredict = is_jmp | (is_cond & (taken != bus.pred_taken));

  assign pc_plus4 = bus.pc + XLEN'(4);
  assign jalr_sum = bus.rs1_data + bus.imm;
  assign target   = (is_jmp && bus.is_jalr) ? {jalr_sum[XLEN-1:1], 1'b0} : bus.pc + bus.imm;
  assign next_pc  = taken ? target : pc_plus4;

  always_comb begin
    taken_d       = taken_q;
    redirect_d    = redirect_q;
    redirect_pc_d = redirect_pc_q;
    link_pc_d     = link_pc_q;
    if (accept) begin
      taken_d       = taken;
      redirect_d    = mispredict;
      redirect_pc_d = next_pc;
      link_pc_d     = pc_plus4;
    end else if (!bus.stall) begin
      taken_d    = 1'b0;
      redirect_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      taken_q       <= 1'b0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      link_pc_q     <= '0;
    end else begin
      taken_q       <= taken_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
      link_pc_q     <= link_pc_d;
    end
  end

  assign ctr_cur = bht_q[res_idx];
  assign bht_we  = accept & is_cond;

  always_comb begin
    ctr_nxt = ctr_cur;
    if (cond_true) begin
      if (ctr_cur != 2'b11) ctr_nxt = ctr_cur + 2'b01;
    end else begin
      if (ctr_cur != 2'b00) ctr_nxt = ctr_cur - 2'b01;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < BHT_DEPTH; i++) bht_q[i] <= BHT_INIT;
    end else if (bht_we) begin
      bht_q[res_idx] <= ctr_nxt;
    end
  end

  assign bus.branch_taken = taken_q;
  assign bus.redirect     = redirect_q;
  assign bus.redirect_pc  = redirect_pc_q;
  assign bus.link_pc      = link_pc_q;

`ifdef BRU_PREDICT_STATS_EN
  logic [31:0] stat_br_q, stat_br_d, stat_mp_q, stat_mp_d;

  always_comb begin
    stat_br_d = stat_br_q;
    stat_mp_d = stat_mp_q;
    if (bht_we) begin
      stat_br_d = stat_br_q + 32'd1;
      if (mispredict) stat_mp_d = stat_mp_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stat_br_q <= '0;
      stat_mp_q <= '0;
    end else begin
      stat_br_q <= stat_br_d;
      stat_mp_q <= stat_mp_d;
    end
  end

  assign bus.stat_branches    = stat_br_q;
  assign bus.stat_mispredicts = stat_mp_q;
`endif
endmodule

// File: tb/tb_bru_predict.sv
// Directed-vector bench for bru_predict: hand-computed direction, target, redirect and BHT effects.
module tb_bru_predict;
  localparam logic [2:0] EQ = 3'd0, NE = 3'd1, LT = 3'd2, GE = 3'd3,
                         LTU = 3'd4, GEU = 3'd5, JMP = 3'd6, UND = 3'd7;

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk = 0;
  int   n_err = 0;

  bru_predict_if #(.XLEN(32)) bus ();

  bru_predict #(.XLEN(32), .BHT_IDX_W(6), .BHT_INIT(2'b01)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic res(input logic [2:0] op, input logic jalr, input logic [31:0] pc,
                     input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                     input logic pred);
    bus.res_valid  = 1'b1;
    bus.bru_op     = op;
    bus.is_jalr    = jalr;
    bus.pc         = pc;
    bus.rs1_data   = a;
    bus.rs2_data   = b;
    bus.imm        = imm;
    bus.pred_taken = pred;
  endtask

  task automatic idle();
    bus.res_valid = 1'b0;
  endtask

  task automatic fpred(input string tag, input logic [31:0] fpc, input logic exp);
    bus.fetch_pc = fpc;
    #1;
    chk(tag, 64'(bus.fetch_pred_taken), 64'(exp));
  endtask

  task automatic outs(input string tag, input logic tk, input logic rd,
                      input logic [31:0] rpc);
    chk({tag, ".taken"},    64'(bus.branch_taken), 64'(tk));
    chk({tag, ".redirect"}, 64'(bus.redirect),     64'(rd));
    chk({tag, ".rpc"},      64'(bus.redirect_pc),  64'(rpc));
  endtask

  initial begin
    rst_n = 1'b0;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    bus.fetch_pc = 32'h40;
    res(EQ, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    idle();
    #12;
    outs("reset", 1'b0, 1'b0, 32'h0);
    chk("reset.link", 64'(bus.link_pc), 64'h0);
    fpred("reset.fpred", 32'h40, 1'b0);
    rst_n = 1'b1;
    tick();
    outs("post_reset", 1'b0, 1'b0, 32'h0);

    // BEQ taken, predicted not-taken
    res(EQ, 1'b0, 32'h100, 32'd5, 32'd5, 32'h20, 1'b0);
    tick();
    outs("beq", 1'b1, 1'b1, 32'h120);
    chk("beq.link", 64'(bus.link_pc), 64'h104);
    idle();
    fpred("beq.fpred", 32'h100, 1'b1);
    tick();
    outs("beq_after", 1'b0, 1'b0, 32'h120);

    // signed vs unsigned compares, back-to-back
    res(LT, 1'b0, 32'h180, 32'hFFFF_FFFF, 32'd1, 32'h10, 1'b1);
    tick();
    outs("blt", 1'b1, 1'b0, 32'h190);
    res(LTU, 1'b0, 32'h184, 32'hFFFF_FFFF, 32'd1, 32'h10, 1'b1);
    tick();
    outs("bltu", 1'b0, 1'b1, 32'h188);
    idle();
    fpred("blt.fpred", 32'h180, 1'b1);
    fpred("bltu.fpred", 32'h184, 1'b0);
    tick();
    res(GE, 1'b0, 32'h410, 32'hFFFF_FFFF, 32'd1, 32'h8, 1'b0);
    tick();
    outs("bge", 1'b0, 1'b0, 32'h414);
    res(GEU, 1'b0, 32'h414, 32'hFFFF_FFFF, 32'd1, 32'h8, 1'b1);
    tick();
    outs("bgeu", 1'b1, 1'b0, 32'h41C);

    // JALR then a wrong-path op right behind it
    res(JMP, 1'b1, 32'h200, 32'h1001, 32'h0, 32'h2, 1'b0);
    tick();
    outs("jalr", 1'b1, 1'b1, 32'h1002);
    chk("jalr.link", 64'(bus.link_pc), 64'h204);
    res(EQ, 1'b0, 32'h308, 32'd7, 32'd7, 32'h40, 1'b0);
    tick();
    outs("squash", 1'b0, 1'b0, 32'h1002);
    chk("squash.link", 64'(bus.link_pc), 64'h204);
    fpred("squash.fpred", 32'h308, 1'b0);
    res(JMP, 1'b0, 32'h220, 32'hFFFF, 32'h0, 32'h80, 1'b0);
    tick();
    outs("jal", 1'b1, 1'b1, 32'h2A0);
    chk("jal.link", 64'(bus.link_pc), 64'h224);
    idle();
    tick();
    // entry shared by 0x100 and 0x200: 2 -> 1 only if the JALR left it alone
    res(EQ, 1'b0, 32'h100, 32'd1, 32'd2, 32'h20, 1'b1);
    tick();
    outs("beq_nt", 1'b0, 1'b1, 32'h104);
    idle();
    fpred("jmp_no_bht", 32'h100, 1'b0);
    tick();

    // saturation: 1 -> 2 -> 3 -> 3 -> 3, then down to 2
    for (int i = 0; i < 4; i++) begin
      res(NE, 1'b0, 32'h40, 32'd1, 32'd2, 32'h40, 1'b1);
      tick();
      outs($sformatf("bne%0d", i), 1'b1, 1'b0, 32'h80);
    end
    fpred("sat.fpred", 32'h40, 1'b1);
    res(NE, 1'b0, 32'h40, 32'd3, 32'd3, 32'h40, 1'b1);
    tick();
    outs("bne_nt", 1'b0, 1'b1, 32'h44);
    idle();
    fpred("sat_dec.fpred", 32'h40, 1'b1);
    tick();

    // undefined op
    res(UND, 1'b0, 32'h48, 32'd1, 32'd1, 32'h10, 1'b1);
    tick();
    outs("undef", 1'b0, 1'b0, 32'h4C);

    // stall freezes outputs and BHT
    res(EQ, 1'b0, 32'h30C, 32'd9, 32'd9, 32'h10, 1'b1);
    tick();
    outs("pre_stall", 1'b1, 1'b0, 32'h31C);
    bus.stall = 1'b1;
    res(EQ, 1'b0, 32'h308, 32'd7, 32'd7, 32'h40, 1'b0);
    repeat (3) tick();
    outs("stall", 1'b1, 1'b0, 32'h31C);
    fpred("stall.fpred", 32'h308, 1'b0);
    bus.stall = 1'b0;
    tick();
    outs("unstall", 1'b1, 1'b1, 32'h348);
    bus.stall = 1'b1;
    repeat (2) tick();
    outs("stall_redir", 1'b1, 1'b1, 32'h348);
    bus.stall = 1'b0;
    idle();
    tick();
    outs("redir_clear", 1'b0, 1'b0, 32'h348);

    // flush squashes without touching the BHT
    bus.flush = 1'b1;
    res(EQ, 1'b0, 32'h308, 32'd7, 32'd7, 32'h40, 1'b0);
    tick();
    outs("flush", 1'b0, 1'b0, 32'h348);
    res(EQ, 1'b0, 32'h180, 32'd1, 32'd2, 32'h40, 1'b1);
    tick();
    fpred("flush.fpred", 32'h180, 1'b1);
    bus.flush = 1'b0;

    // reset mid-stream
    res(NE, 1'b0, 32'h40, 32'd1, 32'd2, 32'h40, 1'b0);
    tick();
    outs("pre_rst", 1'b1, 1'b1, 32'h80);
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    outs("mid_rst", 1'b0, 1'b0, 32'h0);
    chk("mid_rst.link", 64'(bus.link_pc), 64'h0);
    fpred("mid_rst.fpred", 32'h40, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/bru_predict.md
Name: bru_predict

Overview:
- Parametrised second-generation branch resolution unit with a built-in bimodal branch history table (BHT) of 2-bit saturating counters.
- Fetch side: combinational taken/not-taken prediction per fetch PC.
- Execute side: resolves conditional branches and JAL/JALR, compares against the prediction carried down the pipe, and issues a registered one-cycle redirect on mispredict.
- Sits in EX, feeding the PC-select mux and the IF/ID/EX flush logic.

Parameters:
- XLEN, 32, datapath/PC width.
- BHT_IDX_W, 6, BHT index width; table depth = 2**BHT_IDX_W.
- BHT_INIT, 2'b01, counter reset value (weakly not-taken).

Ports:
- Clk  input  1  system clock, rising edge.
- RstN  input  1  asynchronous active-low reset.
- FetchPc  input  XLEN  PC being fetched.
- FetchPredTaken  output  1  prediction for FetchPc (combinational).
- ResValid  input  1  EX holds a branch/jump to resolve.
- Stall  input  1  hold EX; no state change.
- Flush  input  1  squash the op currently in EX.
- BRUOp  input  3  `BRU_EQ/NE/LT/GE/LTU/GEU/JMP encodings from Constants.vh.
- IsJalr  input  1  JMP is JALR (target from Rs1Data).
- Pc  input  XLEN  PC of resolving op.
- Rs1Data  input  XLEN  operand 1.
- Rs2Data  input  XLEN  operand 2.
- Imm  input  XLEN  sign-extended offset.
- PredTaken  input  1  prediction made at fetch for this op.
- BranchTaken  output  1  registered resolved direction.
- Redirect  output  1  registered one-cycle mispredict pulse.
- RedirectPc  output  XLEN  registered correct next PC.
- LinkPc  output  XLEN  registered Pc+4 for rd of JAL/JALR.

Behaviour:
- Reset (RstN=0, async): BranchTaken=0, Redirect=0, RedirectPc=0, LinkPc=0, all BHT entries = BHT_INIT. Reset mid-operation discards any in-flight resolution.
- BHT index = addr[BHT_IDX_W+1:2]. FetchPredTaken = BHT[FetchPc idx][1].
- Fetch reads return the pre-edge value; a same-cycle update to that index is not forwarded.
- Accept = ResValid & ~Stall & ~Flush & ~Redirect. An op arriving while Redirect=1 is wrong-path and is squashed internally.
- Direction: signed/unsigned compares per BRUOp. JMP is always taken. Undefined BRUOp: not taken, no redirect, no BHT update.
- Target:
  - IsJalr: (Rs1Data+Imm) & ~1.
  - Otherwise: Pc+Imm.
  - All sums modulo 2**XLEN.
- Next PC = taken ? target : Pc+4.
- Mispredict:
  - Conditional: taken != PredTaken.
  - JMP: always mispredicts (front end does not predict jumps).
- Latency 1. On the edge where Accept=1: BranchTaken<=taken, LinkPc<=Pc+4, RedirectPc<=next PC, Redirect<=mispredict.
- Edge with Accept=0 and Stall=0: Redirect<=0, BranchTaken<=0; RedirectPc and LinkPc hold.
- Stall=1: all registers and BHT hold. Redirect stays asserted if already set; downstream must not stall on a redirect cycle.
- BHT update on Accept for conditional ops only:
  - Taken: counter+1, saturating at 3.
  - Not taken: counter-1, saturating at 0.
  - JMP and undefined ops do not touch the BHT.
- Flush has priority over Stall for squashing. Flush does not alter BHT or clear an already-registered Redirect.

Optional Feature:
- Macro BRU_PREDICT_STATS_EN.
- Defined: adds outputs StatBranches[31:0] and StatMispredicts[31:0].
  - Reset to 0.
  - On each Accept of a conditional op: StatBranches+1; if mispredict, also StatMispredicts+1.
  - Both wrap at 2**32.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset release, FetchPc=0x40 -> FetchPredTaken=0; all outputs 0.
- BEQ Pc=0x100, Rs1=Rs2=5, Imm=0x20, PredTaken=0, ResValid=1 -> next cycle Redirect=1, RedirectPc=0x120, BranchTaken=1; BHT[0x100 idx] becomes 2, so FetchPc=0x100 now predicts 1.
- BLT Rs1=0xFFFFFFFF, Rs2=1 -> taken. BLTU with the same operands -> not taken. For BLTU with PredTaken=1: Redirect=1, RedirectPc=Pc+4.
- JALR Pc=0x200, Rs1=0x1001, Imm=2 -> Redirect=1, RedirectPc=0x1002, LinkPc=0x204, BHT unchanged. Back-to-back ResValid the next cycle is squashed: Redirect deasserts, no BHT update.
- Four taken BNEs on the same PC -> counter saturates at 3. One not-taken -> 2, prediction still 1, Redirect=1 with RedirectPc=Pc+4.
- Stall=1 with ResValid=1 for 3 cycles -> outputs and BHT frozen. Flush=1 with ResValid=1 -> no Redirect, no update. Assert RstN=0 mid-stream -> outputs clear immediately and the BHT returns to 01.
